// File: rtl/signal_reduction_pkg.sv
// Shared constants and encodings for narrowing 16-bit signed datapath values
// to 11-bit signed operand/address fields.
package signal_reduction_pkg;

    localparam int LEN_DATA = 16;
    localparam int LEN_ADDR = 11;
    localparam int LEN_CNT  = 8;

    localparam int OVF_CNT_MAX = (1 << LEN_CNT) - 1;

    // Encoding of the sat_mode control bit, shared with the control unit.
    typedef enum logic {
        SAT_WRAP  = 1'b0,
        SAT_CLAMP = 1'b1
    } sat_mode_e;

    function automatic int SAT_POS(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int SAT_NEG(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/signal_reduction_core.sv
// Combinational narrowing of a signed word to a shorter signed field,
// with range detection and either clamp or two's-complement wrap.
module signal_reduction_core
    import signal_reduction_pkg::*;
#(
    parameter int len_data = LEN_DATA,
    parameter int len_addr = LEN_ADDR
) (
    input  logic [len_data-1:0] data_i,
    input  sat_mode_e           sat_mode_i,
    output logic [len_addr-1:0] operand_o,
    output logic                overflow_o
);

    localparam logic [len_addr-1:0] POS_LIM = len_addr'(SAT_POS(len_addr));
    localparam logic [len_addr-1:0] NEG_LIM = len_addr'(SAT_NEG(len_addr));

    // The value fits exactly when every bit from the output sign position
    // upward is a copy of the input sign.
    logic [len_data-len_addr:0] upper_bits;
    logic                       ovf;

    assign upper_bits = data_i[len_data-1:len_addr-1];

    always_comb begin
        ovf       = !((&upper_bits) || !(|upper_bits));
        operand_o = data_i[len_addr-1:0];
        if (ovf && (sat_mode_i == SAT_CLAMP)) begin
            operand_o = data_i[len_data-1] ? NEG_LIM : POS_LIM;
        end
        overflow_o = ovf;
    end

endmodule

// File: rtl/signal_reduction.sv
// Registered signed narrowing stage with sticky overflow and saturating event count.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; the held result is stable while stalled.
module signal_reduction
    import signal_reduction_pkg::*;
#(
    parameter int len_data = LEN_DATA,
    parameter int len_addr = LEN_ADDR,
    parameter int len_cnt  = LEN_CNT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [len_data-1:0] in_data,
    input  logic                sat_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [len_addr-1:0] out_operand,
    output logic                out_overflow,
    output logic                ovf_sticky,
    output logic [len_cnt-1:0]  ovf_count,
    input  logic                clr_status
);

    localparam logic [len_cnt-1:0] CNT_MAX = {len_cnt{1'b1}};

    logic                out_valid_q,    out_valid_d;
    logic [len_addr-1:0] out_operand_q,  out_operand_d;
    logic                out_overflow_q, out_overflow_d;
    logic                ovf_sticky_q,   ovf_sticky_d;
    logic [len_cnt-1:0]  ovf_count_q,    ovf_count_d;

    logic                in_xfer;
    logic                out_xfer;
    logic [len_addr-1:0] nar_operand;
    logic                nar_overflow;

    signal_reduction_core #(
        .len_data (len_data),
        .len_addr (len_addr)
    ) u_core (
        .data_i     (in_data),
        .sat_mode_i (sat_mode_e'(sat_mode)),
        .operand_o  (nar_operand),
        .overflow_o (nar_overflow)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    // A new result always wins over draining, so same-edge transfers keep out_valid high.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_operand_d  = out_operand_q;
        out_overflow_d = out_overflow_q;
        if (in_xfer) begin
            out_valid_d    = 1'b1;
            out_operand_d  = nar_operand;
            out_overflow_d = nar_overflow;
        end else if (out_xfer) begin
            out_valid_d    = 1'b0;
        end
    end

    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        ovf_count_d  = ovf_count_q;
        if (clr_status) begin
            ovf_sticky_d = 1'b0;
            ovf_count_d  = '0;
        end else if (in_xfer && nar_overflow) begin
            ovf_sticky_d = 1'b1;
            if (ovf_count_q != CNT_MAX) begin
                ovf_count_d = ovf_count_q + len_cnt'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_operand_q  <= '0;
            out_overflow_q <= 1'b0;
            ovf_sticky_q   <= 1'b0;
            ovf_count_q    <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_operand_q  <= out_operand_d;
            out_overflow_q <= out_overflow_d;
            ovf_sticky_q   <= ovf_sticky_d;
            ovf_count_q    <= ovf_count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_operand  = out_operand_q;
    assign out_overflow = out_overflow_q;
    assign ovf_sticky   = ovf_sticky_q;
    assign ovf_count    = ovf_count_q;

endmodule
